// File: rtl/menu_pkg.sv
// -----------------------------------------------------------------------------
// menu_pkg
// Shared constants and small arithmetic helpers for the menu controller.
//   - Menu state encoding (this value drives toggle_menu directly).
//   - MAIN menu row indices.
//   - Colour channel count and wrap helpers for select_color / GRAPH_STATE.
// -----------------------------------------------------------------------------
package menu_pkg;

  localparam logic [1:0] MENU_OFF    = 2'd0;
  localparam logic [1:0] MENU_MAIN   = 2'd1;
  localparam logic [1:0] MENU_COLOUR = 2'd2;

  localparam logic [1:0] ROW_HEADER  = 2'd0;
  localparam logic [1:0] ROW_COLOUR  = 2'd1;
  localparam logic [1:0] ROW_EXIT    = 2'd2;
  localparam logic [1:0] ROW_GRAPH   = 2'd3;

  localparam logic [1:0] NUM_COLOR_CH = 2'd3;

  // Graph mode step up; the sum is formed at 6 bits so NUM_GRAPHS=32 wraps too.
  function automatic logic [4:0] graph_inc(input logic [4:0] g, input int unsigned n);
    logic [5:0] nxt;
    logic [5:0] lim;
    lim = n[5:0];
    nxt = {1'b0, g} + 6'd1;
    return (nxt >= lim) ? 5'd0 : nxt[4:0];
  endfunction

  function automatic logic [4:0] graph_dec(input logic [4:0] g, input int unsigned n);
    logic [4:0] top;
    top = 5'(n - 1);
    return (g == 5'd0) ? top : g - 5'd1;
  endfunction

  function automatic logic [1:0] color_inc(input logic [1:0] c);
    return (c == NUM_COLOR_CH - 2'd1) ? 2'd0 : c + 2'd1;
  endfunction

  function automatic logic [1:0] color_dec(input logic [1:0] c);
    return (c == 2'd0) ? NUM_COLOR_CH - 2'd1 : c - 2'd1;
  endfunction

endpackage

// File: rtl/menu_controller_btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// One pushbutton input path: 2-flop synchroniser, counting debouncer and a
// one-cycle press strobe on each accepted 0->1 transition.
// Ports:
//   clk    - slow_clock domain
//   reset  - synchronous, active-high
//   btn    - raw asynchronous, bouncy button
//   level  - debounced button level
//   press  - 1-cycle strobe, registered, on a qualified debounced rising edge
// Parameters:
//   DEBOUNCE_CYCLES - stable cycles needed before the level flips (1..255)
// -----------------------------------------------------------------------------
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic level,
  output logic press
);

  localparam logic [7:0] LAST = 8'(DEBOUNCE_CYCLES - 1);

  logic       sync1;
  logic       sync2;
  logic [7:0] cnt;
  logic [1:0] warm_q;
  logic       armed;
  logic       flip;

  assign flip = (sync2 != level) && (cnt == LAST);

  // armed: a press only counts once the button has been seen released after
  // reset. warm_q waits out the synchroniser so its reset zeros are not taken
  // as a real release of a button that was held through reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      cnt    <= 8'd0;
      level  <= 1'b0;
      press  <= 1'b0;
      warm_q <= 2'b00;
      armed  <= 1'b0;
    end else begin
      sync1  <= btn;
      sync2  <= sync1;
      warm_q <= {warm_q[0], 1'b1};
      if (sync2 != level) begin
        if (flip) begin
          level <= ~level;
          cnt   <= 8'd0;
        end else begin
          cnt <= cnt + 8'd1;
        end
      end else begin
        cnt <= 8'd0;
      end
      armed <= armed | (warm_q[1] & ~sync2 & ~level);
      press <= flip & ~level & armed;
    end
  end

endmodule

// File: rtl/menu_controller.sv
// -----------------------------------------------------------------------------
// menu_controller
// Turns five raw pushbuttons into the menu state consumed by the VGA menu
// renderer. The FSM state is toggle_menu itself (OFF / MAIN / COLOUR).
// Ports:
//   slow_clock, reset (sync, active-high)
//   btn_up, btn_down, btn_left, btn_right, btn_centre - raw buttons
//   toggle_menu  [1:0] - 0 OFF, 1 MAIN, 2 COLOUR
//   select_wave  [1:0] - highlighted MAIN row
//   select_color [1:0] - colour channel under edit (0..2)
//   GRAPH_STATE  [4:0] - graph mode, always < NUM_GRAPHS
//   left, right        - 1-cycle step pulses to the colour editor (COLOUR only)
// Optional build macro: MENU_AUTOREPEAT_EN - held left/right generate repeat
//   events after REPEAT_DELAY cycles, then every REPEAT_CYCLES cycles.
// Event strobes are single-cycle; no back-pressure exists anywhere.
// -----------------------------------------------------------------------------
module menu_controller
  import menu_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int NUM_GRAPHS      = 20,
  parameter int REPEAT_DELAY    = 8,
  parameter int REPEAT_CYCLES   = 4
) (
  input  logic       slow_clock,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_centre,
  output logic [1:0] toggle_menu,
  output logic [1:0] select_wave,
  output logic [1:0] select_color,
  output logic [4:0] GRAPH_STATE,
  output logic       left,
  output logic       right
);

  // Index order: [4] centre, [3] up, [2] down, [1] left, [0] right
  logic [4:0] raw;
  logic [4:0] lvl;
  logic [4:0] prs;
  logic       ev_c, ev_u, ev_d, ev_l, ev_r;

  assign raw = {btn_centre, btn_up, btn_down, btn_left, btn_right};

  for (genvar i = 0; i < 5; i++) begin : g_btn
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk   (slow_clock),
      .reset (reset),
      .btn   (raw[i]),
      .level (lvl[i]),
      .press (prs[i])
    );
  end

`ifdef MENU_AUTOREPEAT_EN
  logic [1:0] rpt;
  wire        unused_lvl = ^lvl[4:2];

  // Repeat timers for left [1] and right [0]. The counter restarts at 1 on
  // the press strobe and on each synthetic event; the first interval is
  // REPEAT_DELAY, later ones REPEAT_CYCLES.
  for (genvar i = 0; i < 2; i++) begin : g_rpt
    logic [7:0] cnt;
    logic       active;
    logic       first;

    assign rpt[i] = active && lvl[i] &&
                    (cnt == (first ? 8'(REPEAT_DELAY) : 8'(REPEAT_CYCLES)));

    always_ff @(posedge slow_clock) begin
      if (reset || !lvl[i]) begin
        active <= 1'b0;
        first  <= 1'b0;
        cnt    <= 8'd0;
      end else if (prs[i]) begin
        active <= 1'b1;
        first  <= 1'b1;
        cnt    <= 8'd1;
      end else if (active) begin
        if (rpt[i]) begin
          first <= 1'b0;
          cnt   <= 8'd1;
        end else begin
          cnt <= cnt + 8'd1;
        end
      end
    end
  end

  assign ev_l = prs[1] | rpt[1];
  assign ev_r = prs[0] | rpt[0];
`else
  wire unused_lvl     = ^lvl;
  wire unused_rpt_cfg = (REPEAT_DELAY > 0) ^ (REPEAT_CYCLES > 0);

  assign ev_l = prs[1];
  assign ev_r = prs[0];
`endif

  assign ev_c = prs[4];
  assign ev_u = prs[3];
  assign ev_d = prs[2];

  // Single FSM; the if/else chain is the arbitration, so only the
  // highest-priority event in a cycle has any effect.
  always_ff @(posedge slow_clock) begin
    if (reset) begin
      toggle_menu  <= MENU_OFF;
      select_wave  <= ROW_HEADER;
      select_color <= 2'd0;
      GRAPH_STATE  <= 5'd0;
      left         <= 1'b0;
      right        <= 1'b0;
    end else begin
      left  <= 1'b0;
      right <= 1'b0;
      if (ev_c) begin
        case (toggle_menu)
          MENU_OFF: begin
            toggle_menu <= MENU_MAIN;
            select_wave <= ROW_HEADER;
          end
          MENU_MAIN: begin
            if (select_wave == ROW_COLOUR)    toggle_menu <= MENU_COLOUR;
            else if (select_wave == ROW_EXIT) toggle_menu <= MENU_OFF;
          end
          MENU_COLOUR: begin
            toggle_menu <= MENU_MAIN;
            select_wave <= ROW_COLOUR;
          end
          default: toggle_menu <= MENU_OFF;
        endcase
      end else if (ev_u) begin
        // 2-bit row index wraps 0->3 on its own
        if (toggle_menu == MENU_MAIN)        select_wave  <= select_wave - 2'd1;
        else if (toggle_menu == MENU_COLOUR) select_color <= color_dec(select_color);
      end else if (ev_d) begin
        if (toggle_menu == MENU_MAIN)        select_wave  <= select_wave + 2'd1;
        else if (toggle_menu == MENU_COLOUR) select_color <= color_inc(select_color);
      end else if (ev_l) begin
        if (toggle_menu == MENU_MAIN && select_wave == ROW_GRAPH)
          GRAPH_STATE <= graph_dec(GRAPH_STATE, NUM_GRAPHS);
        else if (toggle_menu == MENU_COLOUR)
          left <= 1'b1;
      end else if (ev_r) begin
        if (toggle_menu == MENU_MAIN && select_wave == ROW_GRAPH)
          GRAPH_STATE <= graph_inc(GRAPH_STATE, NUM_GRAPHS);
        else if (toggle_menu == MENU_COLOUR)
          right <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_menu_controller.sv
// -----------------------------------------------------------------------------
// tb_menu_controller
// Directed, table-driven bench for menu_controller (DEBOUNCE_CYCLES=4,
// NUM_GRAPHS=20, REPEAT_DELAY=8, REPEAT_CYCLES=4). Inputs are driven and
// outputs sampled on the falling edge of slow_clock.
// -----------------------------------------------------------------------------
module tb_menu_controller;

  // ---------------- clock / reset ----------------
  logic slow_clock = 1'b0;
  logic reset      = 1'b1;
  always #5 slow_clock = ~slow_clock;

  logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0;
  logic       btn_right = 1'b0, btn_centre = 1'b0;
  logic [1:0] toggle_menu, select_wave, select_color;
  logic [4:0] GRAPH_STATE;
  logic       left, right;

  menu_controller #(
    .DEBOUNCE_CYCLES(4), .NUM_GRAPHS(20), .REPEAT_DELAY(8), .REPEAT_CYCLES(4)
  ) dut (
    .slow_clock   (slow_clock),
    .reset        (reset),
    .btn_up       (btn_up),
    .btn_down     (btn_down),
    .btn_left     (btn_left),
    .btn_right    (btn_right),
    .btn_centre   (btn_centre),
    .toggle_menu  (toggle_menu),
    .select_wave  (select_wave),
    .select_color (select_color),
    .GRAPH_STATE  (GRAPH_STATE),
    .left         (left),
    .right        (right)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [10:0] exp_q[$];
  int  cyc = 0;
  int  l_cnt = 0;
  int  r_cnt = 0;
  int  r_times[$];

  // Pulse monitor: counts cycles with left/right high and logs right times.
  always @(negedge slow_clock) begin
    cyc <= cyc + 1;
    if (left)  l_cnt <= l_cnt + 1;
    if (right) begin
      r_cnt <= r_cnt + 1;
      r_times.push_back(cyc);
    end
  end

  typedef struct {
    string      name;
    logic [4:0] btn;   // {centre, up, down, left, right}
    logic [1:0] t, w, c;
    logic [4:0] g;
    int         nl, nr;
  } step_t;

  step_t steps[$];

  function automatic step_t mk(input string name, input logic [4:0] btn,
                               input logic [1:0] t, input logic [1:0] w,
                               input logic [1:0] c, input logic [4:0] g,
                               input int nl, input int nr);
    step_t s;
    s.name = name; s.btn = btn; s.t = t; s.w = w; s.c = c; s.g = g;
    s.nl = nl; s.nr = nr;
    return s;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge slow_clock);
  endtask

  task automatic set_btn(input logic [4:0] m);
    {btn_centre, btn_up, btn_down, btn_left, btn_right} = m;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic clear_pulses();
    l_cnt = 0;
    r_cnt = 0;
    r_times.delete();
  endtask

  // Clean press held 7 cycles, then released and allowed to settle.
  task automatic apply_step(input step_t s);
    logic [10:0] got;
    clear_pulses();
    set_btn(s.btn);
    tick(7);
    set_btn(5'b0);
    tick(10);
    exp_q.push_back({s.t, s.w, s.c, s.g});
    got = {toggle_menu, select_wave, select_color, GRAPH_STATE};
    check({s.name, " state"}, 32'(got), 32'(exp_q.pop_front()));
    check({s.name, " left_pulses"},  32'(l_cnt), 32'(s.nl));
    check({s.name, " right_pulses"}, 32'(r_cnt), 32'(s.nr));
  endtask

  // ---------------- test ----------------
  initial begin
    // Vector table, starting from MAIN row 0, colour 0, graph 0.
    steps.push_back(mk("down1",     5'b00100, 1, 1, 0,  0, 0, 0));
    steps.push_back(mk("down2",     5'b00100, 1, 2, 0,  0, 0, 0));
    steps.push_back(mk("down3",     5'b00100, 1, 3, 0,  0, 0, 0));
    steps.push_back(mk("down_wrap", 5'b00100, 1, 0, 0,  0, 0, 0));
    steps.push_back(mk("up_wrap",   5'b01000, 1, 3, 0,  0, 0, 0));
    steps.push_back(mk("g_left0",   5'b00010, 1, 3, 0, 19, 0, 0));
    steps.push_back(mk("g_right19", 5'b00001, 1, 3, 0,  0, 0, 0));
    steps.push_back(mk("g_left_b",  5'b00010, 1, 3, 0, 19, 0, 0));
    steps.push_back(mk("up_left",   5'b01010, 1, 2, 0, 19, 0, 0));
    steps.push_back(mk("up_row1",   5'b01000, 1, 1, 0, 19, 0, 0));
    steps.push_back(mk("c_colour",  5'b10000, 2, 1, 0, 19, 0, 0));
    steps.push_back(mk("col_d1",    5'b00100, 2, 1, 1, 19, 0, 0));
    steps.push_back(mk("col_d2",    5'b00100, 2, 1, 2, 19, 0, 0));
    steps.push_back(mk("col_d3",    5'b00100, 2, 1, 0, 19, 0, 0));
    steps.push_back(mk("col_u0",    5'b01000, 2, 1, 2, 19, 0, 0));
    steps.push_back(mk("col_u2",    5'b01000, 2, 1, 1, 19, 0, 0));
    steps.push_back(mk("col_right", 5'b00001, 2, 1, 1, 19, 0, 1));
    steps.push_back(mk("col_left",  5'b00010, 2, 1, 1, 19, 1, 0));
    steps.push_back(mk("col_lr",    5'b00011, 2, 1, 1, 19, 1, 0));
    steps.push_back(mk("col_back",  5'b10000, 1, 1, 1, 19, 0, 0));
    steps.push_back(mk("down_exit", 5'b00100, 1, 2, 1, 19, 0, 0));
    steps.push_back(mk("c_exit",    5'b10000, 0, 2, 1, 19, 0, 0));
    steps.push_back(mk("off_up",    5'b01000, 0, 2, 1, 19, 0, 0));
    steps.push_back(mk("off_left",  5'b00010, 0, 2, 1, 19, 0, 0));
    steps.push_back(mk("off_right", 5'b00001, 0, 2, 1, 19, 0, 0));
    steps.push_back(mk("off_down",  5'b00100, 0, 2, 1, 19, 0, 0));
    steps.push_back(mk("c_open",    5'b10000, 1, 0, 1, 19, 0, 0));
    steps.push_back(mk("down_r1",   5'b00100, 1, 1, 1, 19, 0, 0));
    steps.push_back(mk("c_col2",    5'b10000, 2, 1, 1, 19, 0, 0));

    // Reset state
    tick(3);
    check("rst toggle_menu",  32'(toggle_menu),  0);
    check("rst select_wave",  32'(select_wave),  0);
    check("rst select_color", 32'(select_color), 0);
    check("rst GRAPH_STATE",  32'(GRAPH_STATE),  0);
    check("rst left_right",   32'({left, right}), 0);
    reset = 1'b0;
    tick(4);

    // Centre latency: first sampled on the next edge, acted on 7 edges later.
    btn_centre = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick(1);
      if (k == 6) check("lat edge6 toggle", 32'(toggle_menu), 0);
      if (k == 7) begin
        check("lat edge7 toggle", 32'(toggle_menu), 1);
        check("lat edge7 wave",   32'(select_wave), 0);
      end
    end
    btn_centre = 1'b0;
    tick(10);
    check("held centre toggle", 32'(toggle_menu), 1);

    // One-cycle glitches on down never pass the debouncer.
    for (int k = 0; k < 6; k++) begin
      btn_down = 1'b1;
      tick(1);
      btn_down = 1'b0;
      tick(2);
    end
    tick(8);
    check("glitch wave", 32'(select_wave), 0);

    foreach (steps[i]) apply_step(steps[i]);

    // Held right in COLOUR: one pulse, or repeats at +0,+8,+12,+16.
    clear_pulses();
    btn_right = 1'b1;
    tick(18);
    btn_right = 1'b0;
    tick(14);
    check("hold left_pulses", 32'(l_cnt), 0);
`ifdef MENU_AUTOREPEAT_EN
    check("hold right_pulses", 32'(r_cnt), 4);
    exp_q.push_back(11'd0);
    exp_q.push_back(11'd8);
    exp_q.push_back(11'd12);
    exp_q.push_back(11'd16);
    for (int i = 0; i < 4; i++) begin
      logic [10:0] e;
      e = exp_q.pop_front();
      if (i < r_times.size())
        check($sformatf("repeat offset %0d", i), 32'(r_times[i] - r_times[0]), 32'(e));
      else
        check($sformatf("repeat offset %0d missing", i), 32'(r_times.size()), 4);
    end
`else
    check("hold right_pulses", 32'(r_cnt), 1);
`endif
    check("hold colour kept", 32'(select_color), 1);

    // Reset with right and centre held: cleared at once, no events until re-press.
    btn_right  = 1'b1;
    btn_centre = 1'b1;
    tick(10);
    reset = 1'b1;
    tick(1);
    check("mid rst toggle",     32'(toggle_menu),  0);
    check("mid rst wave",       32'(select_wave),  0);
    check("mid rst color",      32'(select_color), 0);
    check("mid rst graph",      32'(GRAPH_STATE),  0);
    check("mid rst left_right", 32'({left, right}), 0);
    reset = 1'b0;
    clear_pulses();
    tick(16);
    check("held thru rst toggle", 32'(toggle_menu), 0);
    check("held thru rst right",  32'(r_cnt), 0);
    btn_right  = 1'b0;
    btn_centre = 1'b0;
    tick(10);
    apply_step(mk("re_open",  5'b10000, 1, 0, 0, 0, 0, 0));
    apply_step(mk("re_down",  5'b00100, 1, 1, 0, 0, 0, 0));
    apply_step(mk("re_col",   5'b10000, 2, 1, 0, 0, 0, 0));
    apply_step(mk("re_right", 5'b00001, 2, 1, 0, 0, 0, 1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
